// File: rtl/pid_plant_model.sv
// First-order-lag plant model (Q4.4 in/out, Q8.8 state) closing the loop around the PID controller.
// Optional dead time on the control input is built when PLANT_DEADTIME_EN is defined.
module pid_plant_model #(
  parameter int                 DIV         = 4,
  parameter int                 ALPHA_SHIFT = 2,
  parameter logic signed [7:0]  Y_INIT      = 8'sd0,
  parameter int                 DELAY       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic signed [7:0] ctrl_in,
  input  logic signed [7:0] dist_in,
  output logic signed [7:0] meas_out,
  output logic              meas_valid,
  output logic              sat_flag
);

  if (DIV < 1 || DIV > 255) begin : g_bad_div
    $error("pid_plant_model: DIV out of range");
  end
  if (ALPHA_SHIFT < 0 || ALPHA_SHIFT > 4) begin : g_bad_alpha
    $error("pid_plant_model: ALPHA_SHIFT out of range");
  end
  if (DELAY < 1 || DELAY > 15) begin : g_bad_delay
    $error("pid_plant_model: DELAY out of range");
  end

  logic [7:0]         cnt;
  logic               tick;
  logic signed [15:0] y, y_next, u16;
  logic signed [16:0] diff, step;
  logic signed [8:0]  sum;
  logic signed [7:0]  u_s;

  assign tick = enable && (cnt == 8'(DIV - 1));

`ifdef PLANT_DEADTIME_EN
  logic signed [7:0] dline [DELAY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) dline[i] <= '0;
    end else if (tick) begin
      dline[0] <= ctrl_in;
      for (int i = 1; i < DELAY; i++) dline[i] <= dline[i-1];
    end
  end

  assign u_s = dline[DELAY-1];
`else
  assign u_s = ctrl_in;
`endif

  // y moves toward u16 by a floored fraction, so it can never overshoot or overflow
  always_comb begin
    u16    = {{4{u_s[7]}}, u_s, 4'b0000};
    diff   = {u16[15], u16} - {y[15], y};
    step   = diff >>> ALPHA_SHIFT;
    y_next = y + step[15:0];
    sum    = {y_next[11], y_next[11:4]} + {dist_in[7], dist_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y          <= {{4{Y_INIT[7]}}, Y_INIT, 4'b0000};
      cnt        <= '0;
      meas_out   <= Y_INIT;
      meas_valid <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      meas_valid <= tick;
      if (enable) cnt <= (cnt == 8'(DIV - 1)) ? 8'd0 : cnt + 8'd1;
      if (tick) begin
        y <= y_next;
        if (sum > 9'sd127) begin
          meas_out <= 8'sd127;
          sat_flag <= 1'b1;
        end else if (sum < -9'sd128) begin
          meas_out <= -8'sd128;
          sat_flag <= 1'b1;
        end else begin
          meas_out <= sum[7:0];
          sat_flag <= 1'b0;
        end
      end
    end
  end

endmodule
